// File: rtl/iiitb_vm_mp.sv
// Vending machine with multiple products: select a product, insert coins,
// get the product plus change, or cancel and get a refund. Each product has
// its own stock counter, and a product stays sold out until reset.
//
// Handshake: sel_valid is a single-cycle strobe. It is accepted only in IDLE
// with an in-range, in-stock selection. out and change_valid are one-cycle
// pulses. prod and change hold meaningful values only while those pulses are
// high, and are 0 otherwise.
module iiitb_vm_mp #(
  parameter int                         N_PROD     = 4,
  parameter int                         PRICE_W    = 4,
  parameter logic [N_PROD*PRICE_W-1:0]  PRICES     = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                         STOCK_W    = 4,
  parameter int                         STOCK_INIT = 3,
  localparam int                        SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1,
  localparam int                        CW         = PRICE_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  input  logic              cancel,
  output logic              out,
  output logic [SEL_W-1:0]  prod,
  output logic [CW-1:0]     change,
  output logic              change_valid,
  output logic              busy,
  output logic [CW-1:0]     credit,
  output logic [N_PROD-1:0] sold_out,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [STOCK_W-1:0] stock_q [N_PROD];
  logic [STOCK_W-1:0] stock_d [N_PROD];

  logic [PRICE_W-1:0] price_sel;
  logic               sel_ok;
  logic [CW-1:0]      coin_val;
  logic [CW-1:0]      credit_nxt;

  // Look up the latched product's price, and check whether the incoming
  // selection is legal. An out-of-range sel matches no product, so it is
  // rejected without any explicit range compare.
  always_comb begin
    price_sel = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_q == SEL_W'(i)) price_sel = PRICES[i*PRICE_W +: PRICE_W];
      if ((sel == SEL_W'(i)) && (stock_q[i] != '0)) sel_ok = 1'b1;
    end
  end

  // Decode the coin into units: 5 -> 1, 10 -> 2, 20 -> 4.
  always_comb begin
    case (in)
      2'b01:   coin_val = CW'(1);
      2'b10:   coin_val = CW'(2);
      2'b11:   coin_val = CW'(4);
      default: coin_val = '0;
    endcase
    credit_nxt = credit_q + coin_val;
  end

  // Next-state logic for the FSM, credit, latched selection and stock.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sel_d    = sel_q;
    stock_d  = stock_q;
    case (state_q)
      S_IDLE: begin
        if (sel_valid && sel_ok) begin
          sel_d    = sel;
          credit_d = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A coin inserted in the same cycle as cancel is still credited,
        // so it is returned as part of the refund.
        credit_d = credit_nxt;
        if (cancel) begin
          state_d = S_REFUND;
        end else if (credit_nxt >= {1'b0, price_sel}) begin
          state_d = S_VEND;
        end
      end
      S_VEND: begin
        for (int i = 0; i < N_PROD; i++) begin
          if ((sel_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end
        credit_d = '0;
        state_d  = S_IDLE;
      end
      S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State registers. A synchronous reset drops any credit without a refund
  // and restocks every product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      sel_q    <= '0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= stock_d[i];
    end
  end

  // Outputs are decoded from registers only, so no input reaches an output
  // combinationally.
  always_comb begin
    out          = (state_q == S_VEND);
    change_valid = (state_q == S_VEND) || (state_q == S_REFUND);
    prod         = (state_q == S_VEND) ? sel_q : '0;
    case (state_q)
      S_VEND:   change = credit_q - {1'b0, price_sel};
      S_REFUND: change = credit_q;
      default:  change = '0;
    endcase
    busy      = (state_q != S_IDLE);
    credit    = credit_q;
    dbg_state = state_q;
    for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: tb/tb_iiitb_vm_mp.sv
// Directed bench for iiitb_vm_mp. The main instance uses the default
// parameters. The second instance has five products and a 3-bit sel, which
// lets the bench drive out-of-range selections.
module tb_iiitb_vm_mp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] in;
  logic       cancel;

  // main instance (defaults)
  logic [1:0] sel;
  logic       sel_valid;
  logic       out, change_valid, busy;
  logic [1:0] prod;
  logic [4:0] change, credit;
  logic [3:0] sold_out;
  logic [1:0] dbg_state;

  // five-product instance
  logic [2:0] sel5;
  logic       sel_valid5;
  logic       out5, change_valid5, busy5;
  logic [2:0] prod5;
  logic [4:0] change5, credit5;
  logic [4:0] sold_out5;
  logic [1:0] dbg_state5;

  iiitb_vm_mp u_dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .sel_valid(sel_valid),
    .cancel(cancel), .out(out), .prod(prod), .change(change),
    .change_valid(change_valid), .busy(busy), .credit(credit),
    .sold_out(sold_out), .dbg_state(dbg_state)
  );

  iiitb_vm_mp #(
    .N_PROD(5),
    .PRICES({4'd2, 4'd6, 4'd5, 4'd4, 4'd3})
  ) u_dut5 (
    .clk(clk), .rst(rst), .in(in), .sel(sel5), .sel_valid(sel_valid5),
    .cancel(cancel), .out(out5), .prod(prod5), .change(change5),
    .change_valid(change_valid5), .busy(busy5), .credit(credit5),
    .sold_out(sold_out5), .dbg_state(dbg_state5)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge and outputs are sampled there too,
  // well away from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] s);
    sel = s; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    in = c;
    tick();
    in = 2'b00;
  endtask

  task automatic check_vend(input string tag, input logic [1:0] p, input logic [4:0] ch);
    check({tag, "_out"}, out, 1);
    check({tag, "_prod"}, prod, p);
    check({tag, "_chg"}, change, ch);
    check({tag, "_cv"}, change_valid, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_out"}, out, 0);
    check({tag, "_cv"}, change_valid, 0);
  endtask

  // Buy product 2 (price 5) using a 20 coin and then a 5 coin.
  task automatic buy_p2(input string tag);
    select(2'd2);
    coin(2'b11);
    coin(2'b01);
    check_vend(tag, 2'd2, 5'd0);
    tick();
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    rst = 1'b1; in = 2'b00; cancel = 1'b0;
    sel = '0; sel_valid = 1'b0; sel5 = '0; sel_valid5 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_sold_out", sold_out, 4'b0000);
    check("reset_state", dbg_state, 0);
    check("reset_prod", prod, 0);
    check("reset_busy5", busy5, 0);

    // Product 0 (price 3): paying 10 + 10 leaves 1 unit of change.
    select(2'd0);
    check("p0_busy", busy, 1);
    check("p0_credit0", credit, 0);
    coin(2'b10);
    check("p0_credit2", credit, 2);
    check("p0_no_out", out, 0);
    coin(2'b10);
    check_vend("p0", 2'd0, 5'd1);
    check("p0_vend_credit", credit, 4);
    in = 2'b11;            // a coin during VEND must not be credited
    tick();
    in = 2'b00;
    check_idle("p0_after");

    // Product 3 (price 6): paying 20 + 10 gives exact money, so change is 0.
    select(2'd3);
    coin(2'b11);
    check("p3_credit4", credit, 4);
    coin(2'b10);
    check_vend("p3", 2'd3, 5'd0);
    tick();
    check_idle("p3_after");

    // Product 1: pay 5, then cancel while inserting 10. The refund is 3 units.
    select(2'd1);
    coin(2'b01);
    in = 2'b10; cancel = 1'b1;
    tick();
    in = 2'b00; cancel = 1'b0;
    check("cancel_out", out, 0);
    check("cancel_cv", change_valid, 1);
    check("cancel_chg", change, 3);
    check("cancel_prod", prod, 0);
    tick();
    check_idle("cancel_after");
    check("cancel_sold_out", sold_out, 4'b0000);

    // Selling product 2 three times empties its stock.
    buy_p2("p2a");
    buy_p2("p2b");
    check("p2_not_yet_out", sold_out, 4'b0000);
    buy_p2("p2c");
    check("p2_sold_out", sold_out, 4'b0100);
    select(2'd2);
    check("p2_ignored_busy", busy, 0);
    tick();
    check("p2_still_sold_out", sold_out, 4'b0100);

    // Coins inserted in IDLE are ignored, so only the later 20 coin counts.
    coin(2'b11);
    coin(2'b10);
    check("idle_coin_credit", credit, 0);
    check("idle_coin_busy", busy, 0);
    select(2'd0);
    coin(2'b11);
    check_vend("idle_coin", 2'd0, 5'd1);
    tick();

    // Reset in the middle of COLLECT drops the credit without a refund pulse.
    select(2'd0);
    coin(2'b10);
    check("mid_credit", credit, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_restock", sold_out, 4'b0000);
    buy_p2("p2_after_rst");

    // Out-of-range selections on the five-product instance are rejected.
    sel5 = 3'd7; sel_valid5 = 1'b1;
    tick();
    check("sel7_busy5", busy5, 0);
    sel5 = 3'd5;
    tick();
    check("sel5_busy5", busy5, 0);
    sel5 = 3'd4;
    tick();
    sel_valid5 = 1'b0;
    check("sel4_busy5", busy5, 1);
    coin(2'b01);
    check("sel4_credit5", credit5, 1);
    coin(2'b01);
    check("sel4_out5", out5, 1);
    check("sel4_prod5", prod5, 4);
    check("sel4_chg5", change5, 0);
    tick();
    check("sel4_idle5", busy5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
